// File: rtl/servo_pwm_pkg.sv
// Shared types and helpers for the multi-channel servo pulse generator.
// Holds the frame state encoding and the width clamp used on every write.
package servo_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  function automatic logic [31:0] clamp(
    input logic [31:0] value,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    if (value < lo) begin
      return lo;
    end
    if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: a shadow width written at any time, an active width
// refreshed only on frame boundaries, and the registered pulse compare.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int CW         = 20,
  parameter int MIN_CYCLES = 36000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic [CW-1:0] i_cnt,
  input  logic          i_wrap,
  input  logic          i_wr,
  input  logic [CW-1:0] i_width,
  output logic          o_pwm
);

  logic [CW-1:0] r_shadow;
  logic [CW-1:0] r_active;
  logic          r_pwm;

  // The active copy reads the pre-write shadow, so a write landing on the
  // boundary cycle is deferred by one full frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= CW'(MIN_CYCLES);
      r_active <= CW'(MIN_CYCLES);
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr) begin
        r_shadow <= i_width;
      end
      if (i_wrap) begin
        r_active <= r_shadow;
      end
      r_pwm <= i_run && (i_cnt < r_active);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/servo_pwm.sv
// Servo pulse generator: shared frame counter and run/stop sequencing,
// write decode with range error, and one channel instance per output.
module servo_pwm
  import servo_pwm_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int PERIOD_CYCLES = 720000,
  parameter int MIN_CYCLES    = 36000,
  parameter int MAX_CYCLES    = 72000,
  localparam int CW           = $clog2(PERIOD_CYCLES),
  localparam int CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CHW-1:0]      wr_channel,
  input  logic [CW-1:0]       wr_width,
  output logic                wr_error,
  output logic                period_start,
  output logic                busy,
  output logic [CHANNELS-1:0] pwm_out
);

  state_e          r_state;
  state_e          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_wrap;
  logic            w_last;
  logic            w_run;
  logic            w_write;
  logic            w_chan_ok;
  logic [CW-1:0]   w_width_clamped;
  logic            r_wr_ready;
  logic            r_wr_error;
  logic            r_period_start;
  logic [CHANNELS-1:0] w_wr_sel;
  logic [CHANNELS-1:0] w_pwm;

  assign w_last          = (r_cnt == CW'(PERIOD_CYCLES - 1));
  assign w_run           = (r_state != IDLE);
  assign w_write         = wr_valid && r_wr_ready;
  assign w_chan_ok       = (32'(wr_channel) < 32'(CHANNELS));
  assign w_width_clamped = CW'(clamp(32'(wr_width), 32'(MIN_CYCLES), 32'(MAX_CYCLES)));

  // w_wrap is the single "load active widths" strobe: the start of a run
  // and every frame boundary that is followed by another running frame.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_wrap       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (enable) begin
          w_state_next = RUN;
          w_wrap       = 1'b1;
        end
      end
      RUN: begin
        w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
        w_wrap     = w_last;
        if (!enable) begin
          w_state_next = STOPPING;
        end
      end
      STOPPING: begin
        w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
        if (enable) begin
          w_state_next = RUN;
          w_wrap       = w_last;
        end else if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_wr_ready     <= 1'b0;
      r_wr_error     <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_wr_ready     <= 1'b1;
      r_wr_error     <= w_write && !w_chan_ok;
      r_period_start <= w_run && (r_cnt == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_wr_sel[gi] = w_write && w_chan_ok && (wr_channel == CHW'(gi));

      servo_pwm_channel #(
        .CW         (CW),
        .MIN_CYCLES (MIN_CYCLES)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .i_run   (w_run),
        .i_cnt   (r_cnt),
        .i_wrap  (w_wrap),
        .i_wr    (w_wr_sel[gi]),
        .i_width (w_width_clamped),
        .o_pwm   (w_pwm[gi])
      );
    end
  endgenerate

  assign wr_ready     = r_wr_ready;
  assign wr_error     = r_wr_error;
  assign period_start = r_period_start;
  assign busy         = w_run;
  assign pwm_out      = w_pwm;

endmodule

// File: tb/tb_servo_pwm.sv
// Bench for servo_pwm: directed frame scenarios plus random traffic, all
// compared each cycle against a frame-level reference model.
module tb_servo_pwm;

  localparam int CH   = 4;
  localparam int P    = 100;
  localparam int MINW = 10;
  localparam int MAXW = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_channel = '0;
  logic [6:0] wr_width = '0;
  logic       wr_ready, wr_error, period_start, busy;
  logic [3:0] pwm_out;

  // Second instance with three channels so a 2-bit channel field can
  // address a non-existent channel.
  logic       b_valid = 1'b0;
  logic [1:0] b_chan = '0;
  logic [6:0] b_width = '0;
  logic       b_ready, b_err, b_ps, b_busy;
  logic [2:0] b_pwm;

  always #5 clk = ~clk;

  servo_pwm #(.CHANNELS(CH), .PERIOD_CYCLES(P), .MIN_CYCLES(MINW), .MAX_CYCLES(MAXW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_channel(wr_channel), .wr_width(wr_width), .wr_error(wr_error),
    .period_start(period_start), .busy(busy), .pwm_out(pwm_out)
  );

  servo_pwm #(.CHANNELS(3), .PERIOD_CYCLES(P), .MIN_CYCLES(MINW), .MAX_CYCLES(MAXW)) dut_b (
    .clk(clk), .reset(reset), .enable(1'b0), .wr_valid(b_valid), .wr_ready(b_ready),
    .wr_channel(b_chan), .wr_width(b_width), .wr_error(b_err),
    .period_start(b_ps), .busy(b_busy), .pwm_out(b_pwm)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: frame position, running/stopping flags, width arrays.
  bit         m_run, m_stop, m_ready, m_ps, m_err;
  int         m_pos;
  int         m_shadow[CH];
  int         m_active[CH];
  logic [3:0] m_pwm;

  int hi[CH];
  int last_hi[CH];
  int gap, last_gap;

  function automatic int clampw(input int w);
    if (w < MINW) return MINW;
    if (w > MAXW) return MAXW;
    return w;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_ready = 0; m_ps = 0; m_err = 0; m_pos = 0; m_pwm = '0;
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = MINW;
      m_active[i] = MINW;
    end
  endtask

  task automatic model_step();
    int  old[CH];
    bit  acc, last;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) m_pwm[i] = m_run && (m_pos < m_active[i]);
    m_ps  = m_run && (m_pos == 0);
    acc   = wr_valid && m_ready;
    m_err = acc && (int'(wr_channel) >= CH);
    old   = m_shadow;
    if (acc && int'(wr_channel) < CH) m_shadow[wr_channel] = clampw(int'(wr_width));
    m_ready = 1;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_pos = 0; m_active = old;
      end
    end else begin
      last  = (m_pos == P - 1);
      m_pos = last ? 0 : m_pos + 1;
      if (!m_stop) begin
        if (last) m_active = old;
        if (!enable) m_stop = 1;
      end else if (enable) begin
        m_stop = 0;
        if (last) m_active = old;
      end else if (last) begin
        m_run = 0; m_stop = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pwm", 32'(pwm_out), 32'(m_pwm));
    check("ctl", 32'({wr_ready, busy, period_start, wr_error}), 32'({m_ready, m_run, m_ps, m_err}));
    if (period_start) begin
      last_hi  = hi;
      last_gap = gap;
      gap = 0;
      for (int i = 0; i < CH; i++) hi[i] = 0;
    end
    gap++;
    for (int i = 0; i < CH; i++) if (pwm_out[i]) hi[i]++;
  endtask

  task automatic wait_ps();
    for (int n = 0; n < 300; n++) begin
      cycle();
      if (period_start) return;
    end
    check("ps_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int p);
    for (int n = 0; n < 300; n++) begin
      if (m_run && m_pos == p) return;
      cycle();
    end
    check("pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic write(input int ch, input int w);
    wr_valid = 1'b1; wr_channel = 2'(ch); wr_width = 7'(w);
    cycle();
    wr_valid = 1'b0;
  endtask

  initial begin
    int lat, n, stop_hi;
    model_reset();
    for (int i = 0; i < CH; i++) begin hi[i] = 0; last_hi[i] = 0; end
    gap = 0; last_gap = 0;

    repeat (3) cycle();
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    cycle();

    // Start-up latency and the baseline frame
    enable = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(); lat++;
      if (pwm_out[0]) break;
    end
    check("start_lat", 32'(lat), 32'd2);
    wait_ps();
    check("base_gap", 32'(last_gap), 32'(P));
    for (int i = 0; i < CH; i++) check("base_w", 32'(last_hi[i]), 32'(MINW));

    // Mid-frame write is deferred to the next frame
    wait_pos(40);
    write(2, 15);
    wait_ps();
    check("ch2_cur", 32'(last_hi[2]), 32'd10);
    wait_ps();
    check("ch2_next", 32'(last_hi[2]), 32'd15);
    check("ch0_same", 32'(last_hi[0]), 32'd10);

    // Clamping at both ends
    write(1, 127);
    wait_ps(); wait_ps();
    check("ch1_hi", 32'(last_hi[1]), 32'(MAXW));
    write(1, 3);
    wait_ps(); wait_ps();
    check("ch1_lo", 32'(last_hi[1]), 32'(MINW));

    // Out-of-range channel on the three-channel instance
    check("b_ready", 32'(b_ready), 32'd1);
    b_valid = 1'b1; b_chan = 2'd3; b_width = 7'd15;
    cycle();
    check("b_err_pulse", 32'(b_err), 32'd1);
    b_valid = 1'b0;
    cycle();
    check("b_err_clr", 32'(b_err), 32'd0);
    b_valid = 1'b1; b_chan = 2'd2;
    cycle();
    check("b_err_valid", 32'(b_err), 32'd0);
    b_valid = 1'b0;

    // Stop request finishes the frame
    wait_pos(5);
    enable = 1'b0;
    n = 0; stop_hi = 0;
    for (int k = 0; k < 200; k++) begin
      cycle(); n++;
      if (pwm_out[0]) stop_hi++;
      if (!busy) break;
    end
    check("stop_len", 32'(n), 32'd95);
    check("stop_hi", 32'(stop_hi), 32'd5);
    repeat (3) cycle();
    check("idle_pwm", 32'(pwm_out), 32'd0);

    // Re-enable during STOPPING keeps frames continuous
    enable = 1'b1;
    wait_ps();
    wait_pos(50); enable = 1'b0;
    wait_pos(80); enable = 1'b1;
    wait_ps();
    check("cont_gap", 32'(last_gap), 32'(P));
    check("cont_w0", 32'(last_hi[0]), 32'd10);

    // Reset in the middle of a pulse
    wait_pos(7);
    #2 reset = 1'b1;
    #1;
    check("rst_async", 32'(pwm_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    cycle(); cycle();
    reset = 1'b0;
    wait_ps(); wait_ps();
    for (int i = 0; i < CH; i++) check("post_rst_w", 32'(last_hi[i]), 32'(MINW));

    // Random traffic
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      wr_valid   = ($urandom_range(0, 9) == 0);
      wr_channel = 2'($urandom_range(0, 3));
      wr_width   = 7'($urandom_range(0, 127));
      reset      = ($urandom_range(0, 999) == 0);
      cycle();
    end
    reset = 1'b0; wr_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
